// File: rtl/fact_accel_rsp.sv
// Memory-mapped factorial accelerator: operand/go/status/result registers
// with an iterative one-multiply-per-cycle engine behind them.
module fact_accel_rsp #(
    parameter int DATA_W = 32,
    parameter int N_MAX  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MULT = 1'b1;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam logic [3:0] N_LIMIT = 4'(N_MAX);

    logic [0:0]        state_reg;
    logic [3:0]        n_reg;
    logic [3:0]        cnt_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] result_reg;
    logic              done_reg;
    logic              err_reg;

    logic busy;
    logic start_req;

    assign busy      = (state_reg == MULT);
    assign start_req = we && (a == ADDR_GO) && wd[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            n_reg      <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            // The operand register stays writable while busy; the engine runs on cnt_reg.
            if (we && (a == ADDR_N)) begin
                n_reg <= wd[3:0];
            end

            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        if (n_reg > N_LIMIT) begin
                            err_reg    <= 1'b1;
                            done_reg   <= 1'b1;
                            result_reg <= '0;
                        end else begin
                            acc_reg   <= {{(DATA_W-1){1'b0}}, 1'b1};
                            cnt_reg   <= n_reg;
                            done_reg  <= 1'b0;
                            err_reg   <= 1'b0;
                            state_reg <= MULT;
                        end
                    end
                end
                MULT: begin
                    // cnt of 0 or 1 finishes on the first MULT cycle, giving 0! = 1! = 1.
                    if (cnt_reg <= 4'd1) begin
                        result_reg <= acc_reg;
                        done_reg   <= 1'b1;
                        state_reg  <= IDLE;
                    end else begin
                        acc_reg <= acc_reg * DATA_W'(cnt_reg);
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            ADDR_N:      rd = DATA_W'(n_reg);
            ADDR_GO:     rd = DATA_W'(busy);
            ADDR_STATUS: rd = DATA_W'({err_reg, done_reg});
            ADDR_RESULT: rd = result_reg;
            default:     rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel_rsp.sv
// Bench for fact_accel_rsp: a transaction-level model checked every cycle,
// plus directed sequences with literal expected results and latencies.
module tb_fact_accel_rsp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    int errors = 0;
    int checks = 0;

    fact_accel_rsp #(.DATA_W(32), .N_MAX(12)) dut (
        .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: a start computes n! at once and counts down the latency.
    logic [3:0]  m_n = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pending = '0;
    int          m_rem = 0;
    logic        m_valid = 1'b0;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * 32'(i);
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_n <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_result <= '0; m_pending <= '0; m_rem <= 0; m_valid <= 1'b1;
        end else begin
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                end
                m_rem <= m_rem - 1;
            end
            if (we && a == 2'd0) m_n <= wd[3:0];
            if (we && a == 2'd1 && wd[0] && !m_busy) begin
                if (int'(m_n) > 12) begin
                    m_err <= 1'b1; m_done <= 1'b1; m_result <= '0;
                end else begin
                    m_busy    <= 1'b1;
                    m_rem     <= (m_n == 0) ? 1 : int'(m_n);
                    m_pending <= fact(int'(m_n));
                    m_done    <= 1'b0;
                    m_err     <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp;
        if (m_valid) begin
            case (a)
                2'd0:    exp = {28'd0, m_n};
                2'd1:    exp = {31'd0, m_busy};
                2'd2:    exp = {30'd0, m_err, m_done};
                default: exp = m_result;
            endcase
            check($sformatf("model_rd_a%0d", a), rd, exp);
        end
    end

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        @(posedge clk); #1;
        we = 1'b0; wd = '0;
        $display("write a=%0d wd=0x%08h", addr, data);
    endtask

    task automatic rdchk(input string name, input logic [1:0] addr, input logic [31:0] exp);
        a = addr; #1;
        check(name, rd, exp);
        $display("read  %s a=%0d rd=0x%08h", name, addr, rd);
    endtask

    // Counts edges after the current point until STATUS.done is seen, bounded.
    task automatic wait_done(output int cycles);
        a = 2'd2; #1;
        cycles = 0;
        while (!rd[0] && cycles < 40) begin
            @(posedge clk); #2;
            cycles++;
        end
    endtask

    task automatic run(input logic [3:0] n, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        wr(2'd0, {28'd0, n});
        wr(2'd1, 32'd1);
        if (exp_lat > 0) begin
            rdchk("accept_status", 2'd2, 32'd0);
            rdchk("accept_busy",   2'd1, 32'd1);
        end else begin
            rdchk("illegal_busy", 2'd1, 32'd0);
        end
        wait_done(cyc);
        check($sformatf("latency_n%0d", n), 32'(cyc), 32'(exp_lat));
        rdchk($sformatf("result_n%0d", n), 2'd3, exp_res);
        rdchk("status_after", 2'd2, (exp_lat > 0) ? 32'd1 : 32'd3);
        rdchk("busy_after", 2'd1, 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; we = 1'b0; a = 2'd0; wd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rdchk("reset_n",      2'd0, 32'd0);
        rdchk("reset_busy",   2'd1, 32'd0);
        rdchk("reset_status", 2'd2, 32'd0);
        rdchk("reset_result", 2'd3, 32'd0);

        run(4'd5, 32'd120, 5);
        run(4'd12, 32'd479001600, 12);
        run(4'd0, 32'd1, 1);
        run(4'd1, 32'd1, 1);
        run(4'd13, 32'd0, 0);
        run(4'd3, 32'd6, 3);

        // Go and N writes while busy must not disturb the computation.
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        wait_done(cyc);
        check("busy_writes_latency", 32'(cyc), 32'd4);
        rdchk("busy_writes_result", 2'd3, 32'd720);
        rdchk("busy_writes_n", 2'd0, 32'd2);

        // Back-to-back: go on the first cycle after done.
        wr(2'd1, 32'd1);
        wait_done(cyc);
        check("b2b_latency", 32'(cyc), 32'd2);
        rdchk("b2b_result", 2'd3, 32'd2);

        // Reset mid-computation.
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rdchk("midrst_busy",   2'd1, 32'd0);
        rdchk("midrst_status", 2'd2, 32'd0);
        rdchk("midrst_result", 2'd3, 32'd0);
        rdchk("midrst_n",      2'd0, 32'd0);
        run(4'd4, 32'd24, 4);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fact_accel_rsp.md
# fact_accel_rsp

CPU-facing responder for the factorial accelerator. It takes word-addressed register writes of the operand `n` and a go command, computes `n!` iteratively with one multiply per cycle, and answers CPU reads with the operand, a busy flag, done/error status and the 32-bit result. It sits on the memory-mapped peripheral bus behind the SoC address decoder and returns its read data through the decoder's read mux.

## Interface
- `DATA_W`, default 32: bus data width and result width.
- `N_MAX`, default 12: largest legal operand; 12! = 479001600 is the largest factorial that fits in 32 bits.

Ports:
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `we` input, 1 bit: write enable; qualified by `a`, sampled on the rising edge.
- `a` input, 2 bits: word address.
- `wd` input, `DATA_W` bits: write data.
- `rd` output, `DATA_W` bits: read data; combinational from `a` and the registers.

## Operation
Register map:
- Address 0 (N), read/write: write stores `wd[3:0]` into `n_reg`; read returns `n_reg` zero-extended.
- Address 1 (GO), write only: a write with `wd[0]=1` is a start request; a write with `wd[0]=0` has no effect. A read returns `{0, busy}`.
- Address 2 (STATUS), read only: returns `{0, err, done}` with `done` in bit 0 and `err` in bit 1. Writes are ignored.
- Address 3 (RESULT), read only: returns `result`. Writes are ignored.

FSM states are IDLE and MULT. `busy` is 1 exactly when the state is MULT.
- IDLE, start accepted, `n_reg > N_MAX`: set `err<=1`, `done<=1`, `result<=0`; stay in IDLE.
- IDLE, start accepted, `n_reg <= N_MAX`: set `acc<=1`, `cnt<=n_reg`, `done<=0`, `err<=0`; go to MULT.
- MULT with `cnt<=1`: set `result<=acc` and `done<=1`; go to IDLE.
- MULT with `cnt>1`: set `acc<=acc*cnt` (low `DATA_W` bits) and `cnt<=cnt-1`; stay in MULT.

Rules:
- A go write while busy is ignored. The computation continues and status is unchanged.
- A write to N while busy updates `n_reg` only. The running computation uses the captured `cnt`.
- `done` and `err` are sticky until the next accepted start or reset. `result` holds until the next completion, error, or reset.
- An accepted start clears `done` and `err` on the accept edge.
- `acc` is `DATA_W` bits wide. For `n <= N_MAX` the product never overflows.

## Timing
Reset values (at the first rising edge with `rst=1`):
- State is IDLE and `busy=0`.
- `n_reg=0`, `done=0`, `err=0`, `result=0`, `acc=0`, `cnt=0`.
- Reset mid-computation aborts immediately with no completion.
- `rst` has priority over a simultaneous write.

Latency, with the go write accepted at edge k:
- Legal `n`: `done=1` is visible after edge k+max(n,1). For example n=0 or 1 gives k+1, n=5 gives k+5, n=12 gives k+12.
- Illegal `n`: `done=1` and `err=1` are visible after edge k, and `busy` is never asserted.
- `busy` rises after edge k and falls after the completion edge, the same edge at which `done` rises.
- `rd` reflects register state in the same cycle, with no read latency. A read of STATUS on the completion cycle boundary returns the post-edge value.
- Back-to-back operation: a go write on the first cycle after `done` rises is accepted.

## Test plan
- Reset, then read all four addresses -> N=0, busy=0, STATUS=0, RESULT=0.
- Write N=5 then GO=1 -> busy=1 for 5 cycles; after that STATUS=0x1, RESULT=120, busy=0.
- Write N=12 then go -> done after 12 cycles with RESULT=479001600 (0x1C8CFC00). Write N=0 then go -> done after 1 cycle with RESULT=1. Repeat with N=1 -> done after 1 cycle with RESULT=1.
- Write N=13 then go -> after 1 edge STATUS=0x3, RESULT=0, busy never 1. Then N=3 and go -> STATUS goes to 0 on the accept edge, then 0x1 with RESULT=6.
- Start N=6; at cycle 2 write N=2 and GO=1 again -> both ignored for the computation; RESULT=720 at k+6; N then reads 2.
- Start N=10, assert `rst` at cycle 4 -> next cycle busy=0, STATUS=0, RESULT=0, N=0; a new start with N=4 then yields 24.
